// File: rtl/wisc_pkg.sv
// Shared flag and branch-condition definitions.
// Used by the ALU, the flag/condition unit and the PC unit.
package wisc_pkg;

    localparam int FLAG_V = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;
    localparam logic [2:0] CC_UN = 3'b111;

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational branch-condition resolver: flags {N,Z,V} + ccc -> true/false.
// Shared with the PC unit's BR path.
module flag_cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] i_flags,
    input  logic [2:0] i_cond,
    output logic       o_cond_true
);

    logic w_n;
    logic w_z;
    logic w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_v = i_flags[FLAG_V];

    // Fully decoded condition table; every ccc value has a defined result.
    always_comb begin
        o_cond_true = 1'b0;
        unique case (i_cond)
            CC_NE: o_cond_true = ~w_z;
            CC_EQ: o_cond_true = w_z;
            CC_GT: o_cond_true = ~w_z & ~w_n;
            CC_LT: o_cond_true = w_n;
            CC_GE: o_cond_true = w_z | ~w_n;
            CC_LE: o_cond_true = w_n | w_z;
            CC_OV: o_cond_true = w_v;
            CC_UN: o_cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural N/Z/V flag register, branch decision and
// saturating taken-branch counter.
module flag_cond_unit
    import wisc_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       flags_in,
    input  logic [2:0]       flag_en,
    input  logic             wr_valid,
    input  logic             br_valid,
    input  logic [2:0]       cond,
    input  logic             cnt_clr,
    output logic [2:0]       flags_q,
    output logic             take_branch,
    output logic [CNT_W-1:0] br_count
);

    logic [2:0]       r_flags;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       w_wr_mask;
    logic [2:0]       w_flags_nxt;
    logic [2:0]       w_eval;
    logic             w_cond_true;
    logic             w_take;
    logic             w_cnt_max;

    // A stalled instruction (wr_valid=0) must not touch any flag bit.
    assign w_wr_mask   = {3{wr_valid}} & flag_en;
    assign w_flags_nxt = (w_wr_mask & flags_in) | (~w_wr_mask & r_flags);

    // With bypass the branch sees the flags this instruction is writing.
    assign w_eval = BYPASS ? w_flags_nxt : r_flags;

    flag_cond_eval u_eval (
        .i_flags     (w_eval),
        .i_cond      (cond),
        .o_cond_true (w_cond_true)
    );

    assign w_take    = br_valid & w_cond_true;
    assign w_cnt_max = &r_cnt;

    // Flag register with per-bit write enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 3'b000;
        end else begin
            r_flags <= w_flags_nxt;
        end
    end

    // Taken-branch counter: clear wins, otherwise saturate at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_take && !w_cnt_max) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign flags_q     = r_flags;
    assign take_branch = w_take;
    assign br_count    = r_cnt;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: two instances (no bypass with a
// 4-bit counter, bypass with a 16-bit counter) against a behavioural model.
module tb_flag_cond_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  flags_in = 3'b000;
    logic [2:0]  flag_en = 3'b000;
    logic        wr_valid = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  cond = 3'b000;
    logic        cnt_clr = 1'b0;

    logic [2:0]  fq0, fq1;
    logic        tb0, tb1;
    logic [3:0]  cnt0;
    logic [15:0] cnt1;

    int n_chk = 0;
    int n_err = 0;

    flag_cond_unit #(.CNT_W(4), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .flag_en(flag_en),
        .wr_valid(wr_valid), .br_valid(br_valid), .cond(cond),
        .cnt_clr(cnt_clr), .flags_q(fq0), .take_branch(tb0), .br_count(cnt0)
    );

    flag_cond_unit #(.CNT_W(16), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .flag_en(flag_en),
        .wr_valid(wr_valid), .br_valid(br_valid), .cond(cond),
        .cnt_clr(cnt_clr), .flags_q(fq1), .take_branch(tb1), .br_count(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Condition table written directly from the ISA definition.
    function automatic bit cond_ref(input logic [2:0] f, input logic [2:0] c);
        bit n, z, v;
        n = f[2];
        z = f[1];
        v = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] flags_after(input logic [2:0] old);
        logic [2:0] r;
        r = old;
        for (int i = 0; i < 3; i++)
            if (wr_valid && flag_en[i]) r[i] = flags_in[i];
        return r;
    endfunction

    // Behavioural model state
    logic [2:0] m_flags;
    int         m_cnt0;
    int         m_cnt1;

    function automatic bit exp_take0();
        return br_valid && cond_ref(m_flags, cond);
    endfunction

    function automatic bit exp_take1();
        return br_valid && cond_ref(flags_after(m_flags), cond);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags <= 3'b000;
            m_cnt0  <= 0;
            m_cnt1  <= 0;
        end else begin
            m_flags <= flags_after(m_flags);
            if (cnt_clr) m_cnt0 <= 0;
            else if (exp_take0() && m_cnt0 < 15) m_cnt0 <= m_cnt0 + 1;
            if (cnt_clr) m_cnt1 <= 0;
            else if (exp_take1() && m_cnt1 < 65535) m_cnt1 <= m_cnt1 + 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("flags_q0", 32'(fq0), 32'(m_flags));
        chk("flags_q1", 32'(fq1), 32'(m_flags));
        chk("take0", 32'(tb0), 32'(exp_take0()));
        chk("take1", 32'(tb1), 32'(exp_take1()));
        chk("count0", 32'(cnt0), 32'(m_cnt0));
        chk("count1", 32'(cnt1), 32'(m_cnt1));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [2:0] f, input logic [2:0] e);
        wr_valid = 1'b1;
        flags_in = f;
        flag_en  = e;
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_flags", 32'(fq0), 32'h0);
        chk("rst_cnt", 32'(cnt0), 32'h0);

        // Test 1: async reset mid-run
        wr_valid = 1'b1; flag_en = 3'b111; flags_in = 3'b111;
        br_valid = 1'b1; cond = 3'b111;
        repeat (5) tick();
        chk("t1_pre_flags", 32'(fq0), 32'h7);
        chk("t1_pre_cnt", 32'(cnt0), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_flags0", 32'(fq0), 32'h0);
        chk("t1_rst_flags1", 32'(fq1), 32'h0);
        chk("t1_rst_cnt0", 32'(cnt0), 32'h0);
        chk("t1_rst_cnt1", 32'(cnt1), 32'h0);
        wr_valid = 1'b0; cond = 3'b000;
        #1;
        chk("t1_ne_take0", 32'(tb0), 32'h1);
        tick();
        rst_n = 1'b1;
        br_valid = 1'b0;

        // Test 2: partial enables
        wr(3'b111, 3'b111);
        chk("t2_all", 32'(fq0), 32'h7);
        wr(3'b000, 3'b010);
        chk("t2_z_only", 32'(fq0), 32'h5);
        wr(3'b111, 3'b000);
        chk("t2_none", 32'(fq0), 32'h5);

        // Test 3: stall blocks writes
        wr_valid = 1'b0; flag_en = 3'b111; flags_in = 3'b010;
        tick();
        chk("t3_stall", 32'(fq0), 32'h5);
        wr_valid = 1'b1;
        tick();
        chk("t3_release", 32'(fq0), 32'h2);

        // Test 4: full condition sweep from stored flags
        for (int f = 0; f < 8; f++) begin
            br_valid = 1'b0;
            wr(3'(f), 3'b111);
            wr_valid = 1'b0;
            for (int c = 0; c < 8; c++) begin
                cond = 3'(c);
                br_valid = 1'b1;
                #1;
                chk("t4_sweep", 32'(tb0), 32'(cond_ref(3'(f), 3'(c))));
                br_valid = 1'b0;
                #1;
                chk("t4_nobr", 32'(tb0), 32'h0);
                tick();
            end
        end

        // Test 5: same-cycle write and branch
        br_valid = 1'b0;
        wr(3'b000, 3'b111);
        wr_valid = 1'b1; flag_en = 3'b111; flags_in = 3'b010;
        cond = 3'b001; br_valid = 1'b1;
        #1;
        chk("t5_nobypass", 32'(tb0), 32'h0);
        chk("t5_bypass", 32'(tb1), 32'h1);
        tick();

        // Test 6: counter saturation and clear priority
        wr_valid = 1'b0;
        br_valid = 1'b0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t6_clr", 32'(cnt0), 32'h0);
        cond = 3'b111; br_valid = 1'b1;
        repeat (20) tick();
        chk("t6_sat", 32'(cnt0), 32'd15);
        chk("t6_wide", 32'(cnt1), 32'd20);
        tick();
        chk("t6_hold", 32'(cnt0), 32'd15);
        cnt_clr = 1'b1;
        tick();
        chk("t6_clr_wins", 32'(cnt0), 32'h0);
        cnt_clr = 1'b0;

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            flags_in = 3'($urandom);
            flag_en  = 3'($urandom);
            wr_valid = 1'($urandom);
            br_valid = 1'($urandom);
            cond     = 3'($urandom);
            cnt_clr  = ($urandom_range(0, 31) == 0);
            tick();
        end

        br_valid = 1'b0;
        cnt_clr = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
